// File: rtl/inv_subbytes_seq.sv
// inv_subbytes_seq: AES decrypt InvSubBytes over a 128-bit state.
// NUM_SBOX inverse S-box lookups are time-shared across the 16 state bytes,
// so a state takes PASSES = 16/NUM_SBOX RUN cycles. Byte 0 is the MSB.
module inv_subbytes_seq #(
    parameter int NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int PASSES = 16 / NUM_SBOX;
    localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;

    generate
        if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
            NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
            $error("inv_subbytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // FIPS-197 inverse S-box, indexed by the input byte value.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    data_q, data_d;
    logic [127:0]    data_sub;
    logic [7:0]      sel_byte [NUM_SBOX];
    logic [7:0]      sub_byte [NUM_SBOX];

    // Lookup lane j substitutes byte cnt*NUM_SBOX+j of the state register.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        data_sub = data_q;
        for (int j = 0; j < NUM_SBOX; j++) begin
            sel_byte[j] = data_q[127 - 8 * (int'(cnt_q) * NUM_SBOX + j) -: 8];
            sub_byte[j] = INV_SBOX[sel_byte[j]];
            data_sub[127 - 8 * (int'(cnt_q) * NUM_SBOX + j) -: 8] = sub_byte[j];
        end
    end

    // Next-state logic: IDLE accepts, RUN substitutes one slice per edge, DONE waits for out_ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_state;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                data_d = data_sub;
                if (cnt_q == CW'(PASSES - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pass counter and state register; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            // NOTE: the 128-bit data register is reset on purpose: out_state must read zero after reset.
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = data_q;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// tb_inv_subbytes_seq: scoreboard bench for inv_subbytes_seq. A driver pushes
// expected results on acceptance; a monitor pops and compares on out handshakes.
module tb_inv_subbytes_seq;

    localparam int PASSES = 4;

    // FIPS-197 forward S-box, used to build stimulus whose inverse is known.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef struct {
        logic [127:0] exp;
        int           e0;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    logic [3:0]   sw_in_valid;
    logic [3:0]   sw_in_ready;
    logic [3:0]   sw_out_valid;
    logic [3:0]   sw_busy;
    logic         sw_out_ready;
    logic [127:0] sw_in_state;
    logic [127:0] sw_out_state [4];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_sent  = 0;
    int   n_recv  = 0;
    int   cyc     = 0;
    int   last_acc = 0;
    int   last_hs  = 0;
    logic hold_ready = 1'b1;
    logic rand_ready = 1'b0;
    exp_t sb_q [$];

    always #5 clk = ~clk;

    // Cycle index: value after edge k is k.
    always @(posedge clk) cyc <= cyc + 1;

    inv_subbytes_seq #(.NUM_SBOX(PASSES == 4 ? 4 : 4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int N = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        inv_subbytes_seq #(.NUM_SBOX(N)) u_sw (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (sw_in_valid[g]),
            .in_ready  (sw_in_ready[g]),
            .in_state  (sw_in_state),
            .out_valid (sw_out_valid[g]),
            .out_ready (sw_out_ready),
            .out_state (sw_out_state[g]),
            .busy      (sw_busy[g])
        );
    end

    function automatic logic [127:0] sub_bytes(input logic [127:0] x);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = SBOX[x[127 - 8*i -: 8]];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Present a state from posedge+1 until accepted; leaves in_valid high.
    task automatic send(input logic [127:0] st, input logic [127:0] exp);
        exp_t e;
        int   w;
        in_valid = 1'b1;
        in_state = st;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.exp = exp;
                e.e0  = cyc + 1;
                sb_q.push_back(e);
                last_acc = cyc + 1;
                n_sent++;
                break;
            end
            w++;
            if (w > 200) begin
                fail_now("accept_timeout");
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        do begin
            @(posedge clk);
            #1;
            w++;
        end while (sb_q.size() != 0 && w < 300);
        if (sb_q.size() != 0) fail_now("drain_timeout");
    endtask

    // One state through sweep instance k; checks latency, busy and result.
    task automatic sweep_one(input int k, input logic [127:0] st, input logic [127:0] exp);
        int n;
        int passes;
        passes = (k == 0) ? 16 : (k == 1) ? 8 : (k == 2) ? 2 : 1;
        sw_in_state    = st;
        sw_in_valid[k] = 1'b1;
        @(negedge clk);
        check($sformatf("sw%0d_in_ready", k), 128'(sw_in_ready[k]), 128'd1);
        @(posedge clk);
        #1;
        sw_in_valid[k] = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (n == 0) check($sformatf("sw%0d_busy", k), 128'(sw_busy[k]), 128'd1);
            if (sw_out_valid[k]) break;
            if (n > 40) begin
                fail_now($sformatf("sw%0d_timeout", k));
                break;
            end
            @(posedge clk);
            n++;
        end
        check($sformatf("sw%0d_latency", k), 128'(n), 128'(passes));
        check($sformatf("sw%0d_data", k), sw_out_state[k], exp);
        @(posedge clk);
        #1;
    endtask

    // Downstream sink: out_ready changes only at posedge+1.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : hold_ready;
        end
    end

    // Monitor: latency on out_valid rise, stability under backpressure, data on handshake.
    initial begin
        logic         prev_ov;
        logic         prev_or;
        logic [127:0] prev_st;
        exp_t         e;
        prev_ov = 1'b0;
        prev_or = 1'b0;
        prev_st = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_ov && !prev_or) begin
                    check("hold_valid", 128'(out_valid), 128'd1);
                    check("hold_state", out_state, prev_st);
                end
                if (out_valid && !prev_ov) begin
                    if (sb_q.size() == 0) fail_now("unexpected_out_valid");
                    else check("latency", 128'(cyc - sb_q[0].e0), 128'(PASSES));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        e = sb_q.pop_front();
                        check("data", out_state, e.exp);
                        n_recv++;
                        last_hs = cyc + 1;
                    end
                end
            end
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_st = out_state;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           a1;
        logic [127:0] x;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_state     = '0;
        sw_in_valid  = '0;
        sw_in_state  = '0;
        sw_out_ready = 1'b1;
        #12;
        check("rst_in_ready",  128'(in_ready),  128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy",      128'(busy),      128'd0);
        check("rst_out_state", out_state,       128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known vector: bytes 00..0f.
        send(128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb);
        in_valid = 1'b0;
        drain();

        // Back-to-back with in_valid held high: II = PASSES+2.
        send({16{8'h63}}, {16{8'h00}});
        a1 = last_acc;
        send({16{8'hff}}, {16{8'h7d}});
        in_valid = 1'b0;
        check("ii", 128'(last_acc - a1), 128'(PASSES + 2));
        drain();

        // Backpressure: out_ready low for ~10 DONE cycles while a new state waits.
        hold_ready = 1'b0;
        send({16{8'h00}}, {16{8'h52}});
        fork
            send({16{8'h01}}, {16{8'h09}});
            begin
                for (int i = 0; i < PASSES + 10; i++) begin
                    @(posedge clk);
                    #2;
                    if (out_valid) check("bp_in_ready", 128'(in_ready), 128'd0);
                end
                hold_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        check("bp_accept_gap", 128'(last_acc - last_hs), 128'd1);
        drain();

        // Reset pulse in the second RUN cycle.
        send(128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("run_busy",     128'(busy),     128'd1);
        check("run_in_ready", 128'(in_ready), 128'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  128'(in_ready),  128'd1);
        check("midrst_busy",      128'(busy),      128'd0);
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_out_state", out_state,       128'd0);
        sb_q.delete();
        n_sent--;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(128'h101112131415161718191a1b1c1d1e1f, 128'h7ce339829b2fff87348e4344c4dee9cb);
        in_valid = 1'b0;
        drain();

        // Random stress with stalls: input SubBytes(x) must come back as x.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            send(sub_bytes(x), x);
            if ($urandom_range(0, 2) != 0) begin
                in_valid = 1'b0;
                in_state = {$urandom, $urandom, $urandom, $urandom};
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
        drain();
        rand_ready = 1'b0;
        check("recv_count", 128'(n_recv), 128'(n_sent));

        // NUM_SBOX sweep: 1, 2, 8, 16 lanes.
        for (int k = 0; k < 4; k++) begin
            sweep_one(k, 128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb);
            for (int r = 0; r < 2; r++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                sweep_one(k, sub_bytes(x), x);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_subbytes_seq.md
Name: inv_subbytes_seq

Overview:
- Sequencer for the AES decrypt inverse SubBytes step over a 128-bit state.
- Time-multiplexes NUM_SBOX internal inverse S-box lookup instances across the 16 state bytes, trading area for latency.
- Sits between the decrypt round controller and the InvShiftRows/AddRoundKey datapath.
- Uses a valid/ready handshake on both input and output, and holds a single state in flight.

Parameters:
- NUM_SBOX, 4: number of inverse S-box lookup instances. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- PASSES, 16/NUM_SBOX: derived localparam, not overridable. It is the number of RUN cycles per state.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  block can accept a state.
- in_state  input  128  ciphertext-side state. Byte i = in_state[127-8i -: 8]; byte 0 is the MSB.
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  inverse-substituted state, same byte order as in_state.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE, pass counter=0, internal state register=0.
  - in_ready=1, out_valid=0, busy=0, out_state=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_state into the state register, counter<=0, go to RUN.
  - With in_valid=0: stay in IDLE, register unchanged.
- RUN:
  - in_ready=0, busy=1.
  - Each edge replaces bytes counter*NUM_SBOX .. counter*NUM_SBOX+NUM_SBOX-1 with their inverse S-box values (FIPS-197 InvSubBytes table) and increments the counter.
  - On the edge where counter=PASSES-1: counter<=0, go to DONE.
  - Exactly PASSES RUN edges occur per state. Each byte is substituted exactly once, never twice.
- DONE:
  - out_valid=1, in_ready=0.
  - out_state equals the state register, stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE, out_valid<=0.
- Latency and throughput:
  - Acceptance edge E0; out_valid is first high after edge E0+PASSES.
  - No input is accepted in the DONE cycle, even with out_ready=1, so there is one IDLE bubble. Minimum initiation interval = PASSES+2 cycles.
- Handshake rules:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside DONE.
  - in_state is sampled only on the acceptance edge; later changes have no effect.
- out_state is driven from the register at all times. It is meaningful only while out_valid=1.
- Inverse S-box lookups are combinational from the register bytes selected by the counter. The counter is $clog2(PASSES) bits, minimum 1 bit.
- With NUM_SBOX=16: PASSES=1 and the counter stays 0; the whole state is substituted in one RUN cycle.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. The partial result is discarded and out_valid is never raised for that state.
- X on in_valid or out_ready in a state where it is ignored must not propagate into the FSM.

Test Plan:
- Reset then in_state=000102030405060708090a0b0c0d0e0f, NUM_SBOX=4, out_ready=1 -> out_valid rises 4 cycles after acceptance; out_state=5209 6ad5 3036 a538 bf40 a39e 81f3 d7fb.
- in_state all bytes 0x63, then all 0xff, back-to-back with in_valid held high -> results all 0x00, then all 0x7d; second acceptance occurs exactly PASSES+2 cycles after the first.
- Backpressure: out_ready=0 for 10 cycles in DONE while in_valid=1 with a new state -> out_valid and out_state stable; in_ready=0; the new state is accepted only after the out handshake plus one IDLE cycle.
- Reset pulse in the 2nd RUN cycle -> in_ready=1, busy=0, out_valid=0, out_state=0 asynchronously; the next accepted state produces a correct, uncorrupted result.
- Sweep NUM_SBOX=1, 2, 8, 16 with input bytes 0x00..0x0f and random states -> out_valid after 16/8/2/1 cycles respectively; every byte matches the reference model InvSubBytes.
- Random 1000-state stress with random in_valid/out_ready stalls -> scoreboard sees results in order, none lost or duplicated, and InvSubBytes(SubBytes(x))=x holds on every result.
